// File: rtl/mcp4911_dac.sv
// SPI write-command transmitter for the MCP4911 10-bit DAC, followed by an LDAC_n latch pulse.
// SCLK_N must be >= 1. N must stay 10 because the command word has a fixed 16-bit layout.
module mcp4911_dac #(
  parameter int unsigned SCLK_N = 4,
  parameter int unsigned N      = 10,
  parameter bit          BUF    = 1'b0,
  parameter bit          GAIN1X = 1'b1
) (
  input  logic         CLK50,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  input  logic         valid,
  output logic         ready,
  output logic         done,
  output logic         SCLK,
  output logic         SDI,
  output logic         CS_n,
  output logic         LDAC_n
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t            state_q, state_d;
  logic [SCLK_N-1:0] div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              ldac_n_q, ldac_n_d;
  logic              accept, tick, last_fall;

  // ready_q is high exactly while idle, so it doubles as the accept qualifier.
  assign accept    = valid && ready_q;
  assign tick      = (div_q == {SCLK_N{1'b1}});
  assign last_fall = tick && sclk_q && (bit_q == 4'd15);

  always_ff @(posedge CLK50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (last_fall) state_d = S_LATCH;
      S_LATCH: if (tick && !ldac_n_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    ldac_n_d = ldac_n_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) begin
          shreg_d = {1'b0, BUF, GAIN1X, 1'b1, din, 2'b00};
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        div_d = div_q + SCLK_N'(1);
        if (tick) begin
          sclk_d = ~sclk_q;
          // Falling edge: advance to the next bit; after 16 shifts the register is all zero.
          if (sclk_q) begin
            shreg_d = {shreg_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd15) cs_n_d = 1'b1;
          end
        end
      end
      S_LATCH: begin
        div_d = div_q + SCLK_N'(1);
        if (tick) begin
          if (ldac_n_q) begin
            ldac_n_d = 1'b0;
          end else begin
            ldac_n_d = 1'b1;
            ready_d  = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign SCLK   = sclk_q;
  assign SDI    = shreg_q[15];
  assign CS_n   = cs_n_q;
  assign LDAC_n = ldac_n_q;

endmodule
